// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage with req/ack memory port, IF/ID register,
// one-entry stall skid buffer and single-delay-slot branch redirect.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ack_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    state_t      state, state_d;
    logic [31:0] pc_q, pc_d, redir_pc, redir_pc_d;
    logic [31:0] skid_pc, skid_pc_d, skid_inst, skid_inst_d;
    logic [31:0] id_pc_d, id_inst_d;
    logic        redir_v, redir_v_d, skid_v, skid_v_d, id_valid_d;

    assign inst_req_o  = state == FETCH;
    assign inst_addr_o = pc_q;

    always_comb begin
        state_d     = state;
        pc_d        = pc_q;
        redir_v_d   = redir_v;
        redir_pc_d  = redir_pc;
        skid_v_d    = skid_v;
        skid_pc_d   = skid_pc;
        skid_inst_d = skid_inst;
        id_pc_d     = id_pc_o;
        id_inst_d   = id_inst_o;
        id_valid_d  = id_valid_o;
        case (state)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (inst_ack_i) begin
                    // a branch seen with the delay slot's ack jumps straight to the target
                    pc_d      = (branch_flag_i && !stall_i) ? branch_target_address_i
                              : redir_v ? redir_pc : pc_q + 32'd4;
                    redir_v_d = 1'b0;
                    if (stall_i) begin
                        skid_pc_d   = pc_q;
                        skid_inst_d = inst_rdata_i;
                        skid_v_d    = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        id_pc_d    = pc_q;
                        id_inst_d  = inst_rdata_i;
                        id_valid_d = 1'b1;
                    end
                end else if (!stall_i) begin
                    id_inst_d  = NOP_INST;
                    id_valid_d = 1'b0;
                    if (branch_flag_i) begin
                        redir_v_d  = 1'b1;
                        redir_pc_d = branch_target_address_i;
                    end
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    id_pc_d    = skid_pc;
                    id_inst_d  = skid_inst;
                    id_valid_d = 1'b1;
                    skid_v_d   = 1'b0;
                    state_d    = FETCH;
                    pc_d       = branch_flag_i ? branch_target_address_i : pc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            redir_v    <= 1'b0;
            redir_pc   <= 32'h0;
            skid_v     <= 1'b0;
            skid_pc    <= 32'h0;
            skid_inst  <= 32'h0;
            id_pc_o    <= 32'h0;
            id_inst_o  <= NOP_INST;
            id_valid_o <= 1'b0;
        end else begin
            state      <= state_d;
            pc_q       <= pc_d;
            redir_v    <= redir_v_d;
            redir_pc   <= redir_pc_d;
            skid_v     <= skid_v_d;
            skid_pc    <= skid_pc_d;
            skid_inst  <= skid_inst_d;
            id_pc_o    <= id_pc_d;
            id_inst_o  <= id_inst_d;
            id_valid_o <= id_valid_d;
        end
    end
endmodule
